// File: rtl/pipe_word_serializer_pkg.sv
// Shared field layout, state type and word-select helpers for the
// 144-bit indication pipe to 32-bit word serializer.
package pipe_word_serializer_pkg;

  localparam int PIPE_W      = 144;
  localparam int WORD_W      = 32;
  localparam int METHOD_LSB  = 128;
  localparam int PORTAL_LSB  = 112;
  localparam int PAYLOAD_LSB = 16;
  localparam int LEN_LSB     = 0;
  localparam int FIELD_W     = 16;
  localparam int MAX_WORDS   = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic logic len_bad(input logic [FIELD_W-1:0] len);
    return (len == 16'd0) || (len > 16'(MAX_WORDS));
  endfunction

  // Length 0 still emits the header; oversize lengths are cut to MAX_WORDS.
  function automatic logic [2:0] clamp_len(input logic [FIELD_W-1:0] len);
    logic [2:0] r;
    if (len == 16'd0) begin
      r = 3'd1;
    end else if (len > 16'(MAX_WORDS)) begin
      r = 3'(MAX_WORDS);
    end else begin
      r = len[2:0];
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] word_sel(input logic [FIELD_W-1:0] method,
                                                 input logic [95:0]        payload,
                                                 input logic [2:0]         eff_len,
                                                 input logic [2:0]         idx);
    logic [WORD_W-1:0] w;
    case (idx)
      3'd0:    w = {method, 13'd0, eff_len};
      3'd1:    w = payload[95:64];
      3'd2:    w = payload[63:32];
      3'd3:    w = payload[31:0];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pipe_word_serializer.sv
// Accepts one packed 144-bit message per handshake and streams it out as a
// header word followed by up to three payload words on a valid/ready link.
module pipe_word_serializer
  import pipe_word_serializer_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enq_ena,
  input  logic [PIPE_W-1:0]    enq_v,
  output logic                 enq_rdy,
  output logic                 out_valid,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_last,
  output logic [FIELD_W-1:0]   out_portal,
  input  logic                 out_ready,
  output logic [COUNT_W-1:0]   msg_count,
  output logic                 len_err
);

  // The length field is folded into eff_len_r, so only the upper fields are held.
  localparam int HOLD_W = PIPE_W - PAYLOAD_LSB;

  state_t              state_r;
  state_t              state_nxt_s;
  state_t              state_base_s;
  logic [HOLD_W-1:0]   msg_r;
  logic [2:0]          eff_len_r;
  logic [2:0]          idx_r;
  logic [COUNT_W-1:0]  count_r;
  logic                err_r;
  logic                last_s;
  logic                beat_s;
  logic                rdy_s;
  logic                accept_s;
  logic [FIELD_W-1:0]  enq_len_s;

  assign enq_len_s = enq_v[LEN_LSB +: FIELD_W];

  // Handshake decode and next-state selection
  always_comb begin
    last_s       = 1'b0;
    beat_s       = 1'b0;
    rdy_s        = 1'b0;
    state_base_s = IDLE;
    case (state_r)
      IDLE: begin
        rdy_s        = 1'b1;
        state_base_s = IDLE;
      end
      SEND: begin
        last_s = (idx_r == (eff_len_r - 3'd1));
        beat_s = out_ready;
        rdy_s  = last_s && out_ready;
        if (beat_s && last_s) begin
          state_base_s = IDLE;
        end else begin
          state_base_s = SEND;
        end
      end
      default: begin
        state_base_s = IDLE;
      end
    endcase
    accept_s    = enq_ena && rdy_s;
    state_nxt_s = accept_s ? SEND : state_base_s;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Message hold, word index, counter and sticky error
  always_ff @(posedge CLK) begin
    if (RST) begin
      msg_r     <= {HOLD_W{1'b0}};
      eff_len_r <= 3'd0;
      idx_r     <= 3'd0;
      count_r   <= {COUNT_W{1'b0}};
      err_r     <= 1'b0;
    end else if (accept_s) begin
      msg_r     <= enq_v[PIPE_W-1:PAYLOAD_LSB];
      eff_len_r <= clamp_len(enq_len_s);
      idx_r     <= 3'd0;
      count_r   <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
      err_r     <= err_r | len_bad(enq_len_s);
    end else if (beat_s && !last_s) begin
      idx_r <= idx_r + 3'd1;
    end
  end

  assign enq_rdy    = rdy_s;
  assign out_valid  = (state_r == SEND);
  assign out_last   = last_s;
  assign out_portal = msg_r[PORTAL_LSB-PAYLOAD_LSB +: FIELD_W];
  assign out_data   = word_sel(msg_r[METHOD_LSB-PAYLOAD_LSB +: FIELD_W],
                               msg_r[95:0], eff_len_r, idx_r);
  assign msg_count  = count_r;
  assign len_err    = err_r;

endmodule

// File: tb/tb_pipe_word_serializer.sv
// Randomized and directed bench for pipe_word_serializer against a
// message-level reference model (word list + position per message).
module tb_pipe_word_serializer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         enq_ena;
  logic [143:0] enq_v;
  logic         enq_rdy;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic [15:0]  out_portal;
  logic         out_ready;
  logic [15:0]  msg_count;
  logic         len_err;

  pipe_word_serializer #(.COUNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .enq_ena(enq_ena), .enq_v(enq_v), .enq_rdy(enq_rdy),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_portal(out_portal), .out_ready(out_ready), .msg_count(msg_count),
    .len_err(len_err)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Reference model: current message as a list of words plus a read position.
  bit          m_active = 1'b0;
  int          m_pos    = 0;
  int          m_len    = 0;
  logic [31:0] m_words [4];
  logic [15:0] m_portal = 16'd0;
  logic [15:0] m_count  = 16'd0;
  bit          m_err    = 1'b0;

  always @(posedge CLK) begin
    bit acc;
    int n;
    if (RST) begin
      m_active = 1'b0; m_pos = 0; m_len = 0; m_count = 16'd0; m_err = 1'b0;
    end else begin
      acc = enq_ena && (!m_active || (m_pos == m_len - 1 && out_ready));
      if (m_active && out_ready) begin
        if (m_pos == m_len - 1) m_active = 1'b0;
        else m_pos++;
      end
      if (acc) begin
        n = int'(enq_v[15:0]);
        if (n == 0 || n > 4) m_err = 1'b1;
        m_len = (n == 0) ? 1 : (n > 4) ? 4 : n;
        m_words[0] = {enq_v[143:128], 16'(m_len)};
        for (int k = 1; k < 4; k++) m_words[k] = enq_v[111 - 32*(k-1) -: 32];
        m_portal = enq_v[127:112];
        m_active = 1'b1;
        m_pos    = 0;
        m_count  = m_count + 16'd1;
      end
    end
  end

  logic [31:0] cap_d [$];
  logic        cap_l [$];
  logic [15:0] cap_p [$];

  // Per-cycle compare and beat capture, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("enq_rdy", enq_rdy, (!m_active || (m_pos == m_len - 1 && out_ready)));
      chk("out_valid", out_valid, m_active);
      if (m_active) begin
        chk("out_data", out_data, m_words[m_pos]);
        chk("out_last", out_last, (m_pos == m_len - 1));
        chk("out_portal", out_portal, m_portal);
      end
      chk("msg_count", msg_count, m_count);
      chk("len_err", len_err, m_err);
      if (out_valid && out_ready) begin
        cap_d.push_back(out_data);
        cap_l.push_back(out_last);
        cap_p.push_back(out_portal);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; enq_ena = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    chk_en = 1'b1;
    cap_d.delete(); cap_l.delete(); cap_p.delete();
  endtask

  task automatic send(input logic [143:0] v);
    enq_v = v; enq_ena = 1'b1;
    tick();
    enq_ena = 1'b0;
  endtask

  initial begin
    RST = 1'b1; enq_ena = 1'b0; enq_v = 144'd0; out_ready = 1'b0;
    do_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_rdy", enq_rdy, 1'b1);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_portal", out_portal, 16'd0);
    chk("rst_count", msg_count, 16'd0);

    // Length-2 message, downstream always ready
    out_ready = 1'b1;
    send({16'd0, 16'd5, 32'hDEADBEEF, 64'd0, 16'd2});
    repeat (3) tick();
    chk("t1_n", cap_d.size(), 2);
    chk("t1_w0", cap_d[0], 32'h00000002);
    chk("t1_w1", cap_d[1], 32'hDEADBEEF);
    chk("t1_l0", cap_l[0], 1'b0);
    chk("t1_l1", cap_l[1], 1'b1);
    chk("t1_portal", cap_p[1], 16'd5);
    chk("t1_count", msg_count, 16'd1);

    // Length-4 message with toggling downstream ready
    do_reset();
    out_ready = 1'b1;
    send({16'h0003, 16'h0003, 96'h11111111_22222222_33333333, 16'd4});
    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    out_ready = 1'b1;
    chk("t2_n", cap_d.size(), 4);
    chk("t2_w0", cap_d[0], 32'h00030004);
    chk("t2_w1", cap_d[1], 32'h11111111);
    chk("t2_w2", cap_d[2], 32'h22222222);
    chk("t2_w3", cap_d[3], 32'h33333333);
    chk("t2_last", {cap_l[0], cap_l[1], cap_l[2], cap_l[3]}, 4'b0001);

    // Back-to-back accept on the final beat
    do_reset();
    out_ready = 1'b1;
    send({16'h0006, 16'd1, 32'hAAAA0001, 64'd0, 16'd2});
    tick();
    chk("t3_lastbeat", out_last, 1'b1);
    chk("t3_rdy", enq_rdy, 1'b1);
    send({16'h0007, 16'd2, 32'hBBBB0001, 64'd0, 16'd2});
    chk("t3_nogap_valid", out_valid, 1'b1);
    chk("t3_nogap_hdr", out_data, 32'h00070002);
    repeat (3) tick();
    chk("t3_n", cap_d.size(), 4);
    chk("t3_w1", cap_d[1], 32'hAAAA0001);
    chk("t3_w2", cap_d[2], 32'h00070002);
    chk("t3_w3", cap_d[3], 32'hBBBB0001);
    chk("t3_count", msg_count, 16'd2);

    // Out-of-range lengths
    do_reset();
    out_ready = 1'b1;
    send({16'h0009, 16'd1, 96'h1, 16'd0});
    repeat (2) tick();
    chk("t4_err_after0", len_err, 1'b1);
    send({16'h000A, 16'd1, 96'h44444444_55555555_66666666, 16'd9});
    repeat (5) tick();
    send({16'h000B, 16'd1, 96'h0, 16'd1});
    repeat (2) tick();
    chk("t4_n", cap_d.size(), 6);
    chk("t4_w0", cap_d[0], 32'h00090001);
    chk("t4_l0", cap_l[0], 1'b1);
    chk("t4_w1", cap_d[1], 32'h000A0004);
    chk("t4_w4", cap_d[4], 32'h66666666);
    chk("t4_l4", cap_l[4], 1'b1);
    chk("t4_sticky", len_err, 1'b1);

    // Reset mid-message
    do_reset();
    out_ready = 1'b1;
    send({16'h000C, 16'd3, 96'h77777777_88888888_99999999, 16'd7});
    tick();
    chk("t5_pre_err", len_err, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_rdy", enq_rdy, 1'b1);
    chk("t5_count", msg_count, 16'd0);
    chk("t5_err", len_err, 1'b0);
    tick();
    chk("t5_still_idle", out_valid, 1'b0);

    // Counter wrap after 65537 single-word messages
    do_reset();
    out_ready = 1'b1;
    enq_v = {16'h0001, 16'd2, 96'd0, 16'd1};
    enq_ena = 1'b1;
    repeat (65536) tick();
    chk("t6_wrap0", msg_count, 16'd0);
    tick();
    enq_ena = 1'b0;
    chk("t6_wrap1", msg_count, 16'd1);
    repeat (2) tick();

    // Randomized traffic, occasional reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      RST       = ($urandom_range(0, 79) == 0);
      enq_ena   = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      enq_v     = {$urandom, $urandom, $urandom, $urandom,
                   ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 6))};
      tick();
    end
    RST = 1'b0; enq_ena = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    chk("end_idle", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
